unidec_encoder: RTL and testbench

//  Message encoder for the 7-word variable-length code {a,c,ad,abb,bad,deb,bbcde}.
//  - Accepts a stream of code-word selects and emits the concatenated character

---
 rtl/unidec_pkg.sv | 46 ++++
 rtl/unidec_code_rom.sv | 14 +
 rtl/unidec_encoder_chk.sv | 20 ++
 rtl/unidec_encoder.sv | 128 ++++++++++++
 tb/tb_unidec_encoder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/unidec_pkg.sv
// Shared definitions for the unique-decipherability encoder/checker pair:
// character codes, packed code-word format, the code-word table and FSM states.
package unidec_pkg;

    localparam int CHAR_W = 3;
    localparam int WORD_W = 16;
    localparam int LEN_W  = 8;

    localparam logic [CHAR_W-1:0] CH_A = 3'b000;
    localparam logic [CHAR_W-1:0] CH_B = 3'b001;
    localparam logic [CHAR_W-1:0] CH_C = 3'b010;
    localparam logic [CHAR_W-1:0] CH_D = 3'b011;
    localparam logic [CHAR_W-1:0] CH_E = 3'b100;

    // Upper part of the shift register when only the stop bit is left above
    // the current character: that character ends its word.
    localparam logic [WORD_W-CHAR_W-1:0] STOP_ONLY = {{(WORD_W-CHAR_W-1){1'b0}}, 1'b1};

    localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Packed word: first character in the low bits, a 1 stop bit just above
    // the last character, zeros above that.
    function automatic logic [WORD_W-1:0] code(input logic [2:0] sel);
        logic [WORD_W-1:0] w;
        case (sel)
            3'd0:    w = WORD_W'({1'b1, CH_A});
            3'd1:    w = WORD_W'({1'b1, CH_C});
            3'd2:    w = WORD_W'({1'b1, CH_D, CH_A});
            3'd3:    w = WORD_W'({1'b1, CH_B, CH_B, CH_A});
            3'd4:    w = WORD_W'({1'b1, CH_D, CH_A, CH_B});
            3'd5:    w = WORD_W'({1'b1, CH_B, CH_E, CH_D});
            3'd6:    w = WORD_W'({1'b1, CH_E, CH_D, CH_C, CH_B, CH_B});
            // select 7 is an alias of "a"
            default: w = WORD_W'({1'b1, CH_A});
        endcase
        return w;
    endfunction

endpackage

// File: rtl/unidec_code_rom.sv
// Combinational code-word lookup: select index to packed word.
module unidec_code_rom
    import unidec_pkg::*;
(
    input  logic [2:0]        sel,
    output logic [WORD_W-1:0] word
);

    // Table lookup through the shared package function.
    always_comb begin
        word = code(sel);
    end

endmodule

// File: rtl/unidec_encoder_chk.sv
// Invariant checker for the encoder: a word in flight always carries its
// stop bit, and only legal characters (a..e) are presented.
module unidec_encoder_chk
    import unidec_pkg::*;
(
    input logic              clk,
    input logic              rst,
    input logic              in_send,
    input logic [WORD_W-1:0] sh,
    input logic              chr_valid,
    input logic [CHAR_W-1:0] chr_data
);

    a_sh_nonzero: assert property (@(posedge clk) disable iff (rst)
        in_send |-> (sh != {WORD_W{1'b0}}));

    a_char_legal: assert property (@(posedge clk) disable iff (rst)
        chr_valid |-> (chr_data <= CH_E));

endmodule

// File: rtl/unidec_encoder.sv
// Variable-length message encoder: turns a stream of code-word selects into
// the concatenated character stream, one character per cycle, with
// end-of-word / end-of-message flags and a saturating message length.
module unidec_encoder
    import unidec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [2:0]        sym_sel,
    input  logic              sym_last,
    output logic              chr_valid,
    input  logic              chr_ready,
    output logic [CHAR_W-1:0] chr_data,
    output logic              chr_eow,
    output logic              chr_eom,
    output logic [LEN_W-1:0]  msg_len
);

    state_t             state_r, state_s;
    logic [WORD_W-1:0]  sh_r, sh_s;
    logic               last_r, last_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic [WORD_W-1:0]  word_s;
    logic               eow_s;
    logic               sym_ready_s;
    logic               chr_valid_s;

    unidec_code_rom u_rom (
        .sel  (sym_sel),
        .word (word_s)
    );

    unidec_encoder_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_send   (state_r == SEND),
        .sh        (sh_r),
        .chr_valid (chr_valid),
        .chr_data  (chr_data)
    );

    // Current character is the last of its word when only the stop bit remains above it.
    always_comb begin
        eow_s = (sh_r[WORD_W-1:CHAR_W] == STOP_ONLY);
    end

    // Next-state, shift-register, length and handshake logic.
    always_comb begin
        state_s     = state_r;
        sh_s        = sh_r;
        last_s      = last_r;
        len_s       = len_r;
        sym_ready_s = 1'b0;
        chr_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                sym_ready_s = 1'b1;
                if (sym_valid) begin
                    sh_s    = word_s;
                    last_s  = sym_last;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                chr_valid_s = 1'b1;
                // a new word may only be taken as the last character of the current one leaves
                sym_ready_s = eow_s & chr_ready;
                if (chr_ready) begin
                    // count survives through the eom cycle, then restarts
                    if (eow_s && last_r) begin
                        len_s = LEN_ZERO;
                    end else if (len_r != LEN_MAX) begin
                        len_s = len_r + LEN_ONE;
                    end else begin
                        len_s = len_r;
                    end
                    if (!eow_s) begin
                        sh_s = sh_r >> CHAR_W;
                    end else if (sym_valid) begin
                        sh_s    = word_s;
                        last_s  = sym_last;
                        state_s = SEND;
                    end else begin
                        // clear so idle outputs stay quiet
                        sh_s    = {WORD_W{1'b0}};
                        state_s = IDLE;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                sh_s    = {WORD_W{1'b0}};
                state_s = IDLE;
            end
        endcase
    end

    // State, word and length registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sh_r    <= {WORD_W{1'b0}};
            last_r  <= 1'b0;
            len_r   <= LEN_ZERO;
        end else begin
            state_r <= state_s;
            sh_r    <= sh_s;
            last_r  <= last_s;
            len_r   <= len_s;
        end
    end

    // Output drive: character and flags come straight from the registered word.
    always_comb begin
        sym_ready = sym_ready_s;
        chr_valid = chr_valid_s;
        chr_data  = sh_r[CHAR_W-1:0];
        chr_eow   = eow_s & (state_r == SEND);
        chr_eom   = eow_s & last_r & (state_r == SEND);
        msg_len   = len_r;
    end

endmodule

// File: tb/tb_unidec_encoder.sv
// Self-checking bench for unidec_encoder: word table plus a character scoreboard.
module tb_unidec_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [2:0] sym_sel = 3'd0;
    logic       sym_last = 1'b0;
    logic       chr_valid;
    logic       chr_ready = 1'b0;
    logic [2:0] chr_data;
    logic       chr_eow;
    logic       chr_eom;
    logic [7:0] msg_len;

    unidec_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_sel   (sym_sel),
        .sym_last  (sym_last),
        .chr_valid (chr_valid),
        .chr_ready (chr_ready),
        .chr_data  (chr_data),
        .chr_eow   (chr_eow),
        .chr_eom   (chr_eom),
        .msg_len   (msg_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] d;
        logic       eow;
        logic       eom;
        logic [7:0] len;
    } exp_t;

    typedef struct {
        logic [2:0]  sel;
        logic        last;
        int          n;
        logic [14:0] chs;
    } vec_t;

    exp_t  q[$];
    int    hs_cyc[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;
    int    hs_cnt = 0;
    int    rdy_mode = 0;
    int    rcnt = 0;
    int    acc_cyc = 0;
    int    mlen = 0;
    string wstr [8] = '{"a", "c", "ad", "abb", "bad", "deb", "bbcde", "a"};
    vec_t  tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [14:0] pk(input logic [2:0] c0, input logic [2:0] c1,
                                       input logic [2:0] c2, input logic [2:0] c3,
                                       input logic [2:0] c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    // Independent model of each code word from its spelling.
    task automatic word_of(input logic [2:0] sel, output int n, output logic [14:0] chs);
        string s;
        s   = wstr[sel];
        n   = s.len();
        chs = 15'd0;
        for (int i = 0; i < n; i++) chs[3*i +: 3] = 3'(s[i] - 8'd97);
    endtask

    // Push expectations, then offer the select until it is accepted.
    task automatic send(input logic [2:0] sel, input logic last, input int n, input logic [14:0] chs);
        exp_t e;
        logic acc;
        for (int i = 0; i < n; i++) begin
            e.d   = chs[3*i +: 3];
            e.eow = (i == n - 1);
            e.eom = last && (i == n - 1);
            e.len = 8'(mlen);
            q.push_back(e);
            if (e.eom) mlen = 0;
            else if (mlen < 255) mlen = mlen + 1;
        end
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            sym_valid = 1'b1;
            sym_sel   = sel;
            sym_last  = last;
            #3;
            acc     = sym_ready;
            acc_cyc = cyc;
            @(posedge clk);
        end
        #1;
        sym_valid = 1'b0;
        if (!acc) check("sym_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_sel(input logic [2:0] sel, input logic last);
        int n;
        logic [14:0] chs;
        word_of(sel, n, chs);
        send(sel, last, n, chs);
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && q.size() != 0; k++) begin
            @(negedge clk);
            #2;
        end
        check("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Cycle counter, read mid-cycle by driver and monitor.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Consumer and scoreboard: drive chr_ready, then compare what is presented.
    initial forever begin
        exp_t e;
        @(negedge clk);
        rcnt = rcnt + 1;
        chr_ready = (rdy_mode == 0) ? 1'b1 : ((rcnt % 3) == 1);
        #1;
        if (!rst && chr_valid) begin
            if (q.size() == 0) begin
                check("unexpected_char", {29'd0, chr_data}, 32'hFFFF);
            end else begin
                e = q[0];
                check("char", {18'd0, chr_data, chr_eow, chr_eom, msg_len, sym_ready},
                      {18'd0, e.d, e.eow, e.eom, e.len, e.eow & chr_ready});
                if (chr_ready) begin
                    void'(q.pop_front());
                    hs_cnt = hs_cnt + 1;
                    hs_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        int b;
        tbl[0] = '{3'd3, 1'b0, 3, pk(3'b000, 3'b001, 3'b001, 3'b000, 3'b000)};
        tbl[1] = '{3'd1, 1'b0, 1, pk(3'b010, 3'b000, 3'b000, 3'b000, 3'b000)};
        tbl[2] = '{3'd5, 1'b0, 3, pk(3'b011, 3'b100, 3'b001, 3'b000, 3'b000)};
        tbl[3] = '{3'd2, 1'b1, 2, pk(3'b000, 3'b011, 3'b000, 3'b000, 3'b000)};
        tbl[4] = '{3'd0, 1'b0, 1, pk(3'b000, 3'b000, 3'b000, 3'b000, 3'b000)};
        tbl[5] = '{3'd6, 1'b0, 5, pk(3'b001, 3'b001, 3'b010, 3'b011, 3'b100)};
        tbl[6] = '{3'd4, 1'b1, 3, pk(3'b001, 3'b000, 3'b011, 3'b000, 3'b000)};

        // reset state
        #12;
        check("rst_outputs", {20'd0, chr_valid, chr_eow, chr_eom, chr_data, msg_len}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // test 1: single "a" message, first char one cycle after acceptance
        b = hs_cyc.size();
        send_sel(3'd0, 1'b1);
        b = acc_cyc;
        drain();
        check("t1_latency", 32'(hs_cyc[0] - b), 32'd1);
        check("t1_len_after", {24'd0, msg_len}, 32'd0);
        check("t1_idle", {31'd0, chr_valid}, 32'd0);

        // test 2: abb,c,deb,ad with no bubbles
        b = hs_cyc.size();
        for (int i = 0; i < 4; i++) send(tbl[i].sel, tbl[i].last, tbl[i].n, tbl[i].chs);
        drain();
        check("t2_count", 32'(hs_cyc.size() - b), 32'd9);
        check("t2_contig", 32'(hs_cyc[b+8] - hs_cyc[b]), 32'd8);

        // test 3: a,bbcde,bad gives the same stream
        b = hs_cyc.size();
        for (int i = 4; i < 7; i++) send(tbl[i].sel, tbl[i].last, tbl[i].n, tbl[i].chs);
        drain();
        check("t3_contig", 32'(hs_cyc[b+8] - hs_cyc[b]), 32'd8);

        // test 4: bbcde under backpressure
        rdy_mode = 1;
        b = hs_cyc.size();
        send_sel(3'd6, 1'b1);
        drain();
        rdy_mode = 0;
        check("t4_count", 32'(hs_cyc.size() - b), 32'd5);
        check("t4_stalled", 32'(hs_cyc[b+4] - hs_cyc[b] > 4), 32'd1);

        // test 5: reset after two characters of bbcde
        b = hs_cnt;
        send_sel(3'd6, 1'b0);
        for (int k = 0; k < 100 && hs_cnt < b + 2; k++) begin
            @(negedge clk);
            #2;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        mlen = 0;
        #1;
        check("t5_rst_valid", {31'd0, chr_valid}, 32'd0);
        check("t5_rst_len", {24'd0, msg_len}, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        send_sel(3'd2, 1'b1);
        drain();
        check("t5_len_after", {24'd0, msg_len}, 32'd0);

        // test 6: saturation, then alias select 7 ends the message
        for (int i = 0; i < 90; i++) send_sel(3'd6, 1'b0);
        send_sel(3'd7, 1'b1);
        drain();
        check("t6_len_cleared", {24'd0, msg_len}, 32'd0);
        check("t6_idle", {31'd0, chr_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
